mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing controller for the shared fixed-latency `multiplier` datapath in the execute stage, serving RV32M MUL/MULH/MULHSU/MULHU. It latches operands on request, drives the multiplier, and waits out its latency. It applies the MULHSU correction that the single-`sign` multiplier cannot do natively, and returns a 32-bit result with a one-cycle `done` pulse. A one-entry operand/product cache lets a MULH*/MUL pair on identical operands complete the second operation without relaunching the multiplier.

## Interface
- `MUL_LATENCY`, default 1: rising edges from stable `a`/`b`/`sign` to valid `product`; 0 means combinational.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: request valid; sampled only when `ready`=1.
- `funct3`  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `rs1`, `rs2`  in  32 each: operands.
- `flush`  in  1: abort the in-flight operation.
- `ready`  out  1: high only in IDLE.
- `done`  out  1: one-cycle pulse; `result` valid in the same cycle.
- `result`  out  32: low word for MUL, high word otherwise.
- `a`, `b`  out  32 each: multiplier operands.
- `sign`  out  1: multiplier signed-mode select.
- `product`  in  64: multiplier output.

## Operation
- States: IDLE, WAIT, FIX, DONE.
- IDLE:
  - `req`=1 and `funct3[2]`=0 is an accept edge (E0).
  - Latch rs1, rs2 and funct3 at E0.
  - `req` with `funct3[2]`=1 is ignored: no accept, `ready` stays 1.
- Cache hit at accept (cache valid, rs1/rs2 equal to the cached operands, and either MUL or mode equal to the cached mode) -> go to DONE; result comes from the cached product.
- Cache miss -> go to WAIT; load the counter with MUL_LATENCY.
- Mode, which drives `sign`:
  - MUL, MULH: signed (`sign`=1).
  - MULHU, MULHSU: unsigned (`sign`=0).
- `a`, `b` and `sign` are registered at E0 and held constant until the next accept.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `product` into the internal 64-bit register P.
  - Then go to FIX if the op is MULHSU and rs1[31]=1; otherwise go to DONE.
- FIX: P <= P - {rs2, 32'h0}, mod 2^64. This is the signed×unsigned identity. Then go to DONE.
- DONE:
  - Assert `done`.
  - `result` = P[31:0] for MUL, P[63:32] otherwise.
  - Write the cache (rs1, rs2, mode, P, valid=1).
  - Return to IDLE.
- Cached P is always the final, corrected product for its mode. A MUL hit may use any mode entry, because the low 32 bits are mode-independent.
- `flush` in WAIT or FIX:
  - Go to IDLE next edge; no `done`.
  - Cache is unchanged and is not written.
- `flush` in IDLE or DONE has no effect. A DONE-cycle `done` still completes.
- `flush` together with `req` in IDLE: `flush` is ignored and the request is accepted.

## Timing
- Reset (any state, including mid-operation):
  - State IDLE.
  - `ready`=1 in the cycle after the reset edge.
  - `done`=0, `result`=0, `a`=0, `b`=0, `sign`=0.
  - Cache invalid, counter 0.
- `done` is high in the cycle after these edges (E0 = accept edge, L = MUL_LATENCY):
  - Cache hit: E0+1.
  - Normal op: E0+L+1.
  - MULHSU with negative rs1: E0+L+2.
- With L=0, `product` is captured at edge E0+1, so DONE follows immediately.
- `ready`=0 from E0 through the DONE cycle. The earliest next accept is the edge ending DONE+1, i.e. `ready` returns the cycle after `done`.
- `done` never holds for two consecutive cycles.
- `result` holds its last value while `done`=0.
- The controller samples `product` only on the counter-zero WAIT cycle.

## Test plan
- MULH rs1=0xFFFFFFFD (-3), rs2=7, L=1 -> `done` at E0+2, `result`=0xFFFFFFFF. Then MUL with the same operands -> cache hit, `done` at E0+1, `result`=0xFFFFFFEB, and `a`/`b` not relaunched.
- MULHSU rs1=0xFFFFFFFF, rs2=0x00000002 -> FIX taken, `done` at E0+3, `result`=0xFFFFFFFF. MULHSU rs1=0x7FFFFFFF, rs2=2 -> no FIX, `result`=0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> `sign`=0, `result`=0xFFFFFFFE. MULH 0x80000000×0x80000000 -> `sign`=1, `result`=0x40000000. Same operands as MULHU, different mode -> cache miss.
- `flush` asserted in WAIT of MULHU 5×6 -> no `done`, `ready`=1 next cycle. A following MUL 5×6 misses the cache and returns 30.
- `rst` asserted in WAIT -> all outputs 0 next cycle. A following MUL on the last cached operands is a miss.
- Sweep rs1, rs2 ∈ [-500, 499] for all four funct3 at L=0, 1 and 3 against the golden 64-bit product, with `req` held high so back-to-back accepts occur. `funct3`=100 -> never accepted.

Source files
------------

// File: rtl/mul_ctrl.sv
// Sequencing controller for the shared fixed-latency multiplier (RV32M MUL/MULH/MULHSU/MULHU).
// Launches operands, waits out the multiplier latency, applies the MULHSU correction and caches one product.
module mul_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        sign,
  input  logic [63:0] product
);

  localparam int CNT_W = (MUL_LATENCY < 2) ? 1 : $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // MULHSU and MULHU share sign=0 but produce different products, so the cache
  // tag separates them: 01 signed x signed, 10 signed x unsigned, 00 unsigned.
  function automatic logic [1:0] op_tag(input logic [1:0] op);
    case (op)
      2'b00, 2'b01: op_tag = 2'b01;
      2'b10:        op_tag = 2'b10;
      default:      op_tag = 2'b00;
    endcase
  endfunction

  function automatic logic [63:0] su_fix(input logic [63:0] p, input logic [31:0] rhs);
    su_fix = p - {rhs, 32'h0};
  endfunction

  function automatic logic [31:0] sel_word(input logic [63:0] p, input logic low);
    sel_word = low ? p[31:0] : p[63:32];
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              sign_q, sign_d;
  logic              c_vld_q, c_vld_d;

  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic [1:0]        op_q, op_d;
  logic [63:0]       p_q, p_d;
  logic [31:0]       c_rs1_q, c_rs1_d;
  logic [31:0]       c_rs2_q, c_rs2_d;
  logic [1:0]        c_tag_q, c_tag_d;
  logic [63:0]       c_p_q, c_p_d;

  logic              accept;
  logic              hit;
  logic              is_mul;
  logic              needs_fix;

  assign accept    = (state_q == S_IDLE) && req && !funct3[2];
  assign hit       = c_vld_q && (rs1 == c_rs1_q) && (rs2 == c_rs2_q) &&
                     ((funct3[1:0] == 2'b00) || (op_tag(funct3[1:0]) == c_tag_q));
  assign is_mul    = (op_q == 2'b00);
  assign needs_fix = (op_q == 2'b10) && rs1_q[31];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    done_d   = 1'b0;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    c_vld_d  = c_vld_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    op_d     = op_q;
    p_d      = p_q;
    c_rs1_d  = c_rs1_q;
    c_rs2_d  = c_rs2_q;
    c_tag_d  = c_tag_q;
    c_p_d    = c_p_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rs1_d   = rs1;
          rs2_d   = rs2;
          op_d    = funct3[1:0];
          hit_d   = hit;
          state_d = S_WAIT;
          if (hit) begin
            // A hit spends one WAIT cycle on the cached product; the multiplier is left alone.
            p_d = c_p_q;
          end else begin
            a_d    = rs1;
            b_d    = rs2;
            sign_d = ~funct3[1];
            cnt_d  = CNT_LOAD;
          end
        end
      end

      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = sel_word(p_q, is_mul);
        end else if (cnt_q == '0) begin
          p_d = product;
          if (needs_fix) begin
            state_d = S_FIX;
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = sel_word(product, is_mul);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          p_d      = su_fix(p_q, rs2_q);
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = sel_word(p_d, is_mul);
        end
      end

      default: begin
        state_d = S_IDLE;
        // A hit must not retag the entry: a MUL hit may sit on an unsigned product.
        if (!hit_q) begin
          c_vld_d = 1'b1;
          c_rs1_d = rs1_q;
          c_rs2_d = rs2_q;
          c_tag_d = op_tag(op_q);
          c_p_d   = p_q;
        end
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      c_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      c_vld_q  <= c_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    op_q    <= op_d;
    p_q     <= p_d;
    c_rs1_q <= c_rs1_d;
    c_rs2_q <= c_rs2_d;
    c_tag_q <= c_tag_d;
    c_p_q   <= c_p_d;
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign a      = a_q;
  assign b      = b_q;
  assign sign   = sign_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl at multiplier latencies 0, 1 and 3, each with its own multiplier model.
module tb_mul_ctrl;
  logic        clk;
  logic        rst;
  logic        req  [3];
  logic [2:0]  f3   [3];
  logic [31:0] r1   [3];
  logic [31:0] r2   [3];
  logic        fl   [3];
  logic        rdy  [3];
  logic        dn   [3];
  logic [31:0] res  [3];
  logic [31:0] ao   [3];
  logic [31:0] bo   [3];
  logic        sg   [3];
  logic [63:0] prod [3];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [63:0] ea, eb, full;
    logic [63:0] pipe [4];

    always_comb begin
      ea   = sg[g] ? {{32{ao[g][31]}}, ao[g]} : {32'h0, ao[g]};
      eb   = sg[g] ? {{32{bo[g][31]}}, bo[g]} : {32'h0, bo[g]};
      full = ea * eb;
    end

    always @(posedge clk) begin
      pipe[0] <= full;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign prod[g] = (L == 0) ? full : pipe[(L == 0) ? 0 : L - 1];

    mul_ctrl #(.MUL_LATENCY(L)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req[g]),
      .funct3  (f3[g]),
      .rs1     (r1[g]),
      .rs2     (r2[g]),
      .flush   (fl[g]),
      .ready   (rdy[g]),
      .done    (dn[g]),
      .result  (res[g]),
      .a       (ao[g]),
      .b       (bo[g]),
      .sign    (sg[g]),
      .product (prod[g])
    );
  end

  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (f[1:0])
      2'b00:   begin p = sx * sy; golden = p[31:0]; end
      2'b01:   begin p = sx * sy; golden = p[63:32]; end
      2'b10:   begin p = sx * uy; golden = p[63:32]; end
      default: begin p = ux * uy; golden = p[63:32]; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int cyc, output logic [31:0] rv);
    req[k] = 1'b1;
    f3[k]  = f;
    r1[k]  = x;
    r2[k]  = y;
    tick();
    req[k] = 1'b0;
    cyc = 0;
    while (dn[k] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (dn[k] !== 1'b1) cyc = -1;
    rv = res[k];
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; fl[k] = 1'b0; f3[k] = 3'b000; r1[k] = '0; r2[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tests += 6;
      if (rdy[k] !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b want 1", k, rdy[k]); end
      if (dn[k] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b want 0", k, dn[k]); end
      if (res[k] !== 32'h0) begin fails++; $display("FAIL reset_result[%0d]: got %h want 0", k, res[k]); end
      if (ao[k] !== 32'h0) begin fails++; $display("FAIL reset_a[%0d]: got %h want 0", k, ao[k]); end
      if (bo[k] !== 32'h0) begin fails++; $display("FAIL reset_b[%0d]: got %h want 0", k, bo[k]); end
      if (sg[k] !== 1'b0) begin fails++; $display("FAIL reset_sign[%0d]: got %b want 0", k, sg[k]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cache();
    int cyc;
    logic [31:0] rv, pa, pb;
    run_op(1, 3'b001, 32'hFFFFFFFD, 32'd7, cyc, rv);
    tests += 2;
    if (cyc != 2) begin fails++; $display("FAIL mulh_latency: got %0d want 2", cyc); end
    if (rv !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulh_result: got %h want ffffffff", rv); end
    pa = ao[1];
    pb = bo[1];
    run_op(1, 3'b000, 32'hFFFFFFFD, 32'd7, cyc, rv);
    tests += 4;
    if (cyc != 1) begin fails++; $display("FAIL hit_latency: got %0d want 1", cyc); end
    if (rv !== 32'hFFFFFFEB) begin fails++; $display("FAIL hit_result: got %h want ffffffeb", rv); end
    if (ao[1] !== pa) begin fails++; $display("FAIL hit_a: got %h want %h", ao[1], pa); end
    if (bo[1] !== pb) begin fails++; $display("FAIL hit_b: got %h want %h", bo[1], pb); end
  endtask

  task automatic test_mulhsu();
    int cyc;
    logic [31:0] rv;
    run_op(1, 3'b010, 32'hFFFFFFFF, 32'h2, cyc, rv);
    tests += 3;
    if (cyc != 3) begin fails++; $display("FAIL mulhsu_fix_latency: got %0d want 3", cyc); end
    if (rv !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu_fix_result: got %h want ffffffff", rv); end
    if (sg[1] !== 1'b0) begin fails++; $display("FAIL mulhsu_sign: got %b want 0", sg[1]); end
    run_op(1, 3'b010, 32'h7FFFFFFF, 32'h2, cyc, rv);
    tests += 2;
    if (cyc != 2) begin fails++; $display("FAIL mulhsu_nofix_latency: got %0d want 2", cyc); end
    if (rv !== 32'h0) begin fails++; $display("FAIL mulhsu_nofix_result: got %h want 0", rv); end
  endtask

  task automatic test_modes();
    int cyc;
    logic [31:0] rv;
    run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, rv);
    tests += 3;
    if (sg[1] !== 1'b0) begin fails++; $display("FAIL mulhu_sign: got %b want 0", sg[1]); end
    if (rv !== 32'hFFFFFFFE) begin fails++; $display("FAIL mulhu_result: got %h want fffffffe", rv); end
    if (cyc != 2) begin fails++; $display("FAIL mulhu_latency: got %0d want 2", cyc); end
    run_op(1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, rv);
    tests += 3;
    if (cyc != 2) begin fails++; $display("FAIL mode_miss_latency: got %0d want 2", cyc); end
    if (rv !== 32'h0) begin fails++; $display("FAIL mode_miss_result: got %h want 0", rv); end
    if (sg[1] !== 1'b1) begin fails++; $display("FAIL mulh_sign: got %b want 1", sg[1]); end
    run_op(1, 3'b001, 32'h80000000, 32'h80000000, cyc, rv);
    tests += 1;
    if (rv !== 32'h40000000) begin fails++; $display("FAIL mulh_min_result: got %h want 40000000", rv); end
  endtask

  task automatic test_latency();
    int cyc;
    logic [31:0] rv;
    run_op(0, 3'b000, 32'd3, 32'd4, cyc, rv);
    tests += 2;
    if (cyc != 1) begin fails++; $display("FAIL lat0_latency: got %0d want 1", cyc); end
    if (rv !== 32'd12) begin fails++; $display("FAIL lat0_result: got %h want c", rv); end
    run_op(2, 3'b010, 32'hFFFFFFFF, 32'h2, cyc, rv);
    tests += 2;
    if (cyc != 5) begin fails++; $display("FAIL lat3_fix_latency: got %0d want 5", cyc); end
    if (rv !== 32'hFFFFFFFF) begin fails++; $display("FAIL lat3_fix_result: got %h want ffffffff", rv); end
    run_op(2, 3'b000, 32'hFFFFFFFF, 32'h2, cyc, rv);
    tests += 2;
    if (cyc != 1) begin fails++; $display("FAIL lat3_hit_latency: got %0d want 1", cyc); end
    if (rv !== 32'hFFFFFFFE) begin fails++; $display("FAIL lat3_hit_result: got %h want fffffffe", rv); end
  endtask

  task automatic test_flush();
    int cyc;
    logic [31:0] rv;
    logic saw_done;
    req[1] = 1'b1; f3[1] = 3'b011; r1[1] = 32'd5; r2[1] = 32'd6;
    tick();
    req[1] = 1'b0;
    fl[1]  = 1'b1;
    tick();
    fl[1]  = 1'b0;
    tests += 2;
    if (rdy[1] !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", rdy[1]); end
    if (dn[1] !== 1'b0) begin fails++; $display("FAIL flush_done: got %b want 0", dn[1]); end
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dn[1] === 1'b1) saw_done = 1'b1;
    end
    tests += 1;
    if (saw_done !== 1'b0) begin fails++; $display("FAIL flush_late_done: got %b want 0", saw_done); end
    run_op(1, 3'b000, 32'd5, 32'd6, cyc, rv);
    tests += 2;
    if (cyc != 2) begin fails++; $display("FAIL flush_then_mul_latency: got %0d want 2", cyc); end
    if (rv !== 32'd30) begin fails++; $display("FAIL flush_then_mul_result: got %h want 1e", rv); end
  endtask

  task automatic test_rst_mid();
    int cyc;
    logic [31:0] rv;
    run_op(1, 3'b000, 32'd9, 32'd11, cyc, rv);
    tests += 1;
    if (rv !== 32'd99) begin fails++; $display("FAIL pre_rst_result: got %h want 63", rv); end
    req[1] = 1'b1; f3[1] = 3'b011; r1[1] = 32'd9; r2[1] = 32'd11;
    tick();
    req[1] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests += 6;
    if (rdy[1] !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", rdy[1]); end
    if (dn[1] !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b want 0", dn[1]); end
    if (res[1] !== 32'h0) begin fails++; $display("FAIL rst_mid_result: got %h want 0", res[1]); end
    if (ao[1] !== 32'h0) begin fails++; $display("FAIL rst_mid_a: got %h want 0", ao[1]); end
    if (bo[1] !== 32'h0) begin fails++; $display("FAIL rst_mid_b: got %h want 0", bo[1]); end
    if (sg[1] !== 1'b0) begin fails++; $display("FAIL rst_mid_sign: got %b want 0", sg[1]); end
    run_op(1, 3'b000, 32'd9, 32'd11, cyc, rv);
    tests += 2;
    if (cyc != 2) begin fails++; $display("FAIL rst_cache_miss_latency: got %0d want 2", cyc); end
    if (rv !== 32'd99) begin fails++; $display("FAIL rst_cache_miss_result: got %h want 63", rv); end
  endtask

  task automatic test_illegal();
    req[1] = 1'b1; f3[1] = 3'b100; r1[1] = 32'd5; r2[1] = 32'd6;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests += 2;
      if (rdy[1] !== 1'b1) begin fails++; $display("FAIL illegal_ready[%0d]: got %b want 1", i, rdy[1]); end
      if (dn[1] !== 1'b0) begin fails++; $display("FAIL illegal_done[%0d]: got %b want 0", i, dn[1]); end
    end
    req[1] = 1'b0;
    f3[1]  = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back(input int k);
    int vals[12] = '{-500, -499, -256, -37, -3, -1, 0, 1, 2, 77, 498, 499};
    int ord[5]   = '{3, 0, 4, 1, 2};
    int idx, guard;
    logic pending, pre_rdy, chk_rdy;
    logic [31:0] exp_r;
    idx = 0; guard = 0; pending = 1'b0; chk_rdy = 1'b0; exp_r = '0;
    req[k] = 1'b1;
    f3[k]  = 3'(ord[0]);
    r1[k]  = 32'(vals[0]);
    r2[k]  = 32'(vals[3]);
    while ((idx < 60 || pending) && guard < 3000) begin
      pre_rdy = rdy[k];
      tick();
      guard++;
      if (chk_rdy) begin
        tests++;
        if (rdy[k] !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_done[%0d]: got %b want 1", k, rdy[k]); end
        chk_rdy = 1'b0;
      end
      if (dn[k] === 1'b1) begin
        tests++;
        if (!pending || res[k] !== exp_r) begin
          fails++;
          $display("FAIL b2b_result[%0d] op %0d: got %h want %h (pending %b)", k, idx, res[k], exp_r, pending);
        end
        pending = 1'b0;
        chk_rdy = 1'b1;
      end
      if (pre_rdy === 1'b1 && idx < 60) begin
        if (f3[k][2] == 1'b0) begin
          pending = 1'b1;
          exp_r   = golden(f3[k], r1[k], r2[k]);
        end else begin
          tests++;
          if (rdy[k] !== 1'b1) begin fails++; $display("FAIL b2b_illegal_accept[%0d]: ready got %b want 1", k, rdy[k]); end
        end
        idx++;
        if (idx < 60) begin
          f3[k] = 3'(ord[idx % 5]);
          r1[k] = 32'(vals[idx / 5]);
          r2[k] = 32'(vals[((idx / 5) * 5 + 3) % 12]);
        end else begin
          req[k] = 1'b0;
        end
      end
    end
    if (guard >= 3000) begin
      tests++;
      fails++;
      $display("FAIL b2b_timeout[%0d]: reached op %0d of 60", k, idx);
    end
    req[k] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cache();
    test_mulhsu();
    test_modes();
    test_latency();
    test_flush();
    test_rst_mid();
    test_illegal();
    for (int k = 0; k < 3; k++) test_back_to_back(k);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
